alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters: the core execute path (requester 0, default priority) and the debug/boot port (requester 1). Accepts one operation per cycle through a request/grant handshake, registers the winning operands onto the ALU inputs, and captures the ALU result. It returns the result to the owning requester with a fixed 2-cycle latency. A bounded-starvation counter guarantees the debug port progress under continuous core traffic.

---
 rtl/alu_arbiter.sv | 86 ++++++++
 tb/tb_alu_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: core has default priority,
// debug is guaranteed a grant after STARVE_LIMIT consecutive contested core grants.
module alu_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_coreReq,
    input  logic [DATA_W-1:0] i_coreSrcA,
    input  logic [DATA_W-1:0] i_coreSrcB,
    input  logic              i_coreOpSel,
    output logic              o_coreGnt,
    output logic              o_coreValid,
    output logic [DATA_W-1:0] o_coreResult,
    input  logic              i_dbgReq,
    input  logic [DATA_W-1:0] i_dbgSrcA,
    input  logic [DATA_W-1:0] i_dbgSrcB,
    input  logic              i_dbgOpSel,
    output logic              o_dbgGnt,
    output logic              o_dbgValid,
    output logic [DATA_W-1:0] o_dbgResult,
    output logic [DATA_W-1:0] o_aluSrcA,
    output logic [DATA_W-1:0] o_aluSrcB,
    output logic              o_aluOpSel,
    input  logic [DATA_W-1:0] i_aluResult
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       vld_p1;
    logic       owner_p1;
    logic       force_dbg;
    logic       any_gnt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= LIMIT) ? LIMIT : v + 4'd1;
    endfunction

    // Stage 0: combinational arbitration, grants held low during reset
    always_comb begin
        force_dbg = i_coreReq && i_dbgReq && (starve_cnt == LIMIT);
        o_coreGnt = i_rstn && i_coreReq && !force_dbg;
        o_dbgGnt  = i_rstn && i_dbgReq && (!i_coreReq || force_dbg);
        any_gnt   = o_coreGnt || o_dbgGnt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_p1       <= 1'b0;
            owner_p1     <= 1'b0;
            o_aluSrcA    <= '0;
            o_aluSrcB    <= '0;
            o_aluOpSel   <= 1'b0;
            o_coreValid  <= 1'b0;
            o_dbgValid   <= 1'b0;
            o_coreResult <= '0;
            o_dbgResult  <= '0;
            starve_cnt   <= 4'd0;
        end else begin
            // Stage 1: winner's operands onto the ALU inputs; hold them when idle
            vld_p1 <= any_gnt;
            if (any_gnt) begin
                owner_p1   <= o_dbgGnt;
                o_aluSrcA  <= o_dbgGnt ? i_dbgSrcA   : i_coreSrcA;
                o_aluSrcB  <= o_dbgGnt ? i_dbgSrcB   : i_coreSrcB;
                o_aluOpSel <= o_dbgGnt ? i_dbgOpSel  : i_coreOpSel;
            end

            // Stage 2: capture the ALU result for its owner
            o_coreValid <= vld_p1 && !owner_p1;
            o_dbgValid  <= vld_p1 && owner_p1;
            if (vld_p1 && !owner_p1)
                o_coreResult <= i_aluResult;
            if (vld_p1 && owner_p1)
                o_dbgResult <= i_aluResult;

            if (!i_dbgReq || o_dbgGnt)
                starve_cnt <= 4'd0;
            else if (o_coreGnt)
                starve_cnt <= sat_inc(starve_cnt);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant rules, queue of in-flight results due at N+2).
module tb_alu_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        core_req, core_op, dbg_req, dbg_op;
    logic [15:0] core_a, core_b, dbg_a, dbg_b;
    logic        core_gnt, core_vld, dbg_gnt, dbg_vld;
    logic [15:0] core_res, dbg_res;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_op;

    always #5 clk = ~clk;

    alu_arbiter #(.STARVE_LIMIT(L), .DATA_W(16)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_coreReq(core_req), .i_coreSrcA(core_a), .i_coreSrcB(core_b), .i_coreOpSel(core_op),
        .o_coreGnt(core_gnt), .o_coreValid(core_vld), .o_coreResult(core_res),
        .i_dbgReq(dbg_req), .i_dbgSrcA(dbg_a), .i_dbgSrcB(dbg_b), .i_dbgOpSel(dbg_op),
        .o_dbgGnt(dbg_gnt), .o_dbgValid(dbg_vld), .o_dbgResult(dbg_res),
        .o_aluSrcA(alu_a), .o_aluSrcB(alu_b), .o_aluOpSel(alu_op),
        .i_aluResult(alu_result)
    );

    assign alu_result = alu_op ? (alu_a + alu_b) : (alu_a ^ alu_b);

    function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b, input logic op);
        return op ? 16'(a + b) : (a ^ b);
    endfunction

    typedef struct {
        int          due;
        logic        dbg;
        logic [15:0] res;
    } op_t;

    op_t         pend[$];
    int          cyc = 0;
    int          m_cnt = 0;
    logic        exp_cg = 1'b0, exp_dg = 1'b0;
    logic        m_cvld = 1'b0, m_dvld = 1'b0, m_op = 1'b0;
    logic [15:0] m_cres = '0, m_dres = '0, m_a = '0, m_b = '0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic calc_gnt();
        exp_cg = 1'b0;
        exp_dg = 1'b0;
        if (rstn) begin
            if (core_req && dbg_req) begin
                if (m_cnt == L) exp_dg = 1'b1;
                else            exp_cg = 1'b1;
            end else begin
                exp_cg = core_req;
                exp_dg = dbg_req;
            end
        end
    endtask

    // Advance one clock: model the edge, then land 1 time unit after it.
    task automatic tick();
        op_t o;
        calc_gnt();
        @(posedge clk);
        cyc++;
        m_cvld = 1'b0;
        m_dvld = 1'b0;
        if (!rstn) begin
            pend.delete();
            m_cres = '0; m_dres = '0; m_a = '0; m_b = '0; m_op = 1'b0; m_cnt = 0;
        end else begin
            if (exp_cg || exp_dg) begin
                m_a  = exp_dg ? dbg_a  : core_a;
                m_b  = exp_dg ? dbg_b  : core_b;
                m_op = exp_dg ? dbg_op : core_op;
                o.due = cyc + 1;
                o.dbg = exp_dg;
                o.res = alu_ref(m_a, m_b, m_op);
                pend.push_back(o);
            end
            if (!dbg_req || exp_dg) m_cnt = 0;
            else if (exp_cg && m_cnt < L) m_cnt++;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                o = pend.pop_front();
                if (o.dbg) begin m_dvld = 1'b1; m_dres = o.res; end
                else       begin m_cvld = 1'b1; m_cres = o.res; end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        core_req = 1'b0;
        dbg_req  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        core_req = 1'b1; core_a = 16'h1111; core_b = 16'h2222; core_op = 1'b0;
        dbg_req  = 1'b1; dbg_a  = 16'h3333; dbg_b  = 16'h4444; dbg_op  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({core_gnt, dbg_gnt} !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_gnt: got %b want 00", {core_gnt, dbg_gnt});
            end
            tick();
        end
        vectors++;
        if ({core_vld, dbg_vld, core_res, dbg_res, alu_a, alu_b, alu_op} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b%b %h %h %h %h %b want all zero",
                     core_vld, dbg_vld, core_res, dbg_res, alu_a, alu_b, alu_op);
        end
        rstn = 1'b1;
        #1;
        vectors++;
        if ({core_gnt, dbg_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release_gnt: got %b want 10", {core_gnt, dbg_gnt});
        end
        tick();
        idle(3);
    endtask

    task automatic test_single_core();
        idle(2);
        core_req = 1'b1; core_a = 16'h12AB; core_b = 16'h0034; core_op = 1'b0;
        #1;
        vectors++;
        if ({core_gnt, dbg_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_gnt: got %b want 10", {core_gnt, dbg_gnt});
        end
        tick();
        core_req = 1'b0;
        vectors++;
        if (alu_a !== 16'h12AB || alu_b !== 16'h0034) begin
            miscompares++;
            $display("FAIL single_alu_src: got %h %h want 12ab 0034", alu_a, alu_b);
        end
        tick();
        vectors++;
        if (core_vld !== 1'b1 || core_res !== 16'h129F) begin
            miscompares++;
            $display("FAIL single_result: got vld=%b res=%h want 1 129f", core_vld, core_res);
        end
        tick();
        vectors++;
        if (core_vld !== 1'b0 || core_res !== 16'h129F) begin
            miscompares++;
            $display("FAIL single_hold: got vld=%b res=%h want 0 129f", core_vld, core_res);
        end
    endtask

    task automatic test_back_to_back();
        idle(2);
        for (int j = 0; j < 5; j++) begin
            core_req = (j < 3);
            core_a = 16'h0000; core_b = 16'(j + 1); core_op = 1'b0;
            if (j < 3) begin
                #1;
                vectors++;
                if (core_gnt !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_gnt%0d: got %b want 1", j, core_gnt);
                end
            end
            tick();
            if (j >= 1) begin
                vectors++;
                if (core_vld !== (j <= 3) || core_res !== 16'(j > 3 ? 3 : j)) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d: got vld=%b res=%h want %b %h",
                             j, core_vld, core_res, (j <= 3), 16'(j > 3 ? 3 : j));
                end
            end
        end
    endtask

    task automatic test_starvation();
        int nd = 0;
        logic want_d;
        idle(2);
        for (int i = 0; i < 12; i++) begin
            core_req = (i < 10); core_a = 16'(i); core_b = 16'h5500; core_op = 1'b0;
            dbg_req  = (i < 10); dbg_a = 16'hD000 + 16'(nd); dbg_b = 16'h0F0F; dbg_op = 1'b0;
            if (i < 10) begin
                want_d = (i % 5 == 4);
                #1;
                vectors++;
                if ({core_gnt, dbg_gnt} !== (want_d ? 2'b01 : 2'b10)) begin
                    miscompares++;
                    $display("FAIL starve_gnt%0d: got %b want %b", i, {core_gnt, dbg_gnt},
                             want_d ? 2'b01 : 2'b10);
                end
                if (want_d) nd++;
            end
            tick();
            if (i >= 1) begin
                want_d = ((i - 1) < 10) && ((i - 1) % 5 == 4);
                vectors++;
                if (dbg_vld !== want_d || core_vld !== (((i - 1) < 10) && !want_d) ||
                    (want_d && dbg_res !== ((16'hD000 + 16'(nd - 1)) ^ 16'h0F0F))) begin
                    miscompares++;
                    $display("FAIL starve_valid%0d: got cv=%b dv=%b dres=%h want cv=%b dv=%b",
                             i, core_vld, dbg_vld, dbg_res, ((i - 1) < 10) && !want_d, want_d);
                end
            end
        end
    endtask

    task automatic test_dropped_request();
        idle(2);
        core_req = 1'b1; core_a = 16'h0101; core_b = 16'h0202; core_op = 1'b1;
        dbg_req  = 1'b1; dbg_a  = 16'hBEEF; dbg_b  = 16'h0001; dbg_op  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (dbg_gnt !== 1'b0 || core_gnt !== 1'b1) begin
                miscompares++;
                $display("FAIL drop_gnt%0d: got %b want 10", i, {core_gnt, dbg_gnt});
            end
            tick();
            dbg_req = 1'b0;
            vectors++;
            if (dbg_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL drop_valid%0d: got %b want 0", i, dbg_vld);
            end
        end
        // counter must restart from zero: four core grants before debug wins
        dbg_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if ({core_gnt, dbg_gnt} !== (i == 4 ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL drop_restart%0d: got %b want %b", i, {core_gnt, dbg_gnt},
                         i == 4 ? 2'b01 : 2'b10);
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_reset_mid_op();
        idle(2);
        core_req = 1'b1; core_a = 16'hAAAA; core_b = 16'h5555; core_op = 1'b0;
        #1;
        vectors++;
        if (core_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_gnt: got %b want 1", core_gnt);
        end
        tick();
        rstn = 1'b0; core_req = 1'b1; dbg_req = 1'b1;
        #1;
        vectors++;
        if ({core_gnt, dbg_gnt} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_forced_gnt: got %b want 00", {core_gnt, dbg_gnt});
        end
        tick();
        rstn = 1'b1; core_req = 1'b0; dbg_req = 1'b0;
        vectors++;
        if ({core_vld, dbg_vld, core_res, dbg_res, alu_a, alu_b, alu_op} !== '0) begin
            miscompares++;
            $display("FAIL midrst_cleared: got %b%b %h %h %h %h %b want all zero",
                     core_vld, dbg_vld, core_res, dbg_res, alu_a, alu_b, alu_op);
        end
        tick();
        vectors++;
        if (core_vld !== 1'b0 || core_res !== 16'h0000) begin
            miscompares++;
            $display("FAIL midrst_no_valid: got vld=%b res=%h want 0 0000", core_vld, core_res);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rstn = ($urandom_range(0, 59) != 0);
            if (core_req && !exp_cg) begin
                if ($urandom_range(0, 7) == 0) core_req = 1'b0;
            end else begin
                core_req = ($urandom_range(0, 3) != 0);
                core_a = 16'($urandom); core_b = 16'($urandom); core_op = 1'($urandom);
            end
            if (dbg_req && !exp_dg) begin
                if ($urandom_range(0, 7) == 0) dbg_req = 1'b0;
            end else begin
                dbg_req = ($urandom_range(0, 1) != 0);
                dbg_a = 16'($urandom); dbg_b = 16'($urandom); dbg_op = 1'($urandom);
            end
            #1;
            calc_gnt();
            vectors++;
            if ({core_gnt, dbg_gnt} !== {exp_cg, exp_dg}) begin
                miscompares++;
                $display("FAIL rand_gnt cyc=%0d: got %b want %b", cyc, {core_gnt, dbg_gnt},
                         {exp_cg, exp_dg});
            end
            tick();
            vectors++;
            if ({core_vld, dbg_vld, core_res, dbg_res, alu_a, alu_b, alu_op} !==
                {m_cvld, m_dvld, m_cres, m_dres, m_a, m_b, m_op}) begin
                miscompares++;
                $display("FAIL rand_out cyc=%0d: got %b%b %h %h %h %h %b want %b%b %h %h %h %h %b",
                         cyc, core_vld, dbg_vld, core_res, dbg_res, alu_a, alu_b, alu_op,
                         m_cvld, m_dvld, m_cres, m_dres, m_a, m_b, m_op);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        core_req = 1'b0; core_a = '0; core_b = '0; core_op = 1'b0;
        dbg_req  = 1'b0; dbg_a  = '0; dbg_b  = '0; dbg_op  = 1'b0;
        test_reset();
        test_single_core();
        test_back_to_back();
        test_starvation();
        test_dropped_request();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
